// File: rtl/hwag_input_pkg.sv
// Shared constants and types for the hwag input conditioner.
package hwag_input_pkg;

    localparam int FILT_W_DEF = 8;
    localparam int PER_W_DEF  = 24;

    typedef logic [PER_W_DEF-1:0] period_t;
    typedef logic [1:0]           blank_shf_t;

    localparam period_t PCNT_MAX = '1;

endpackage

// File: rtl/hwag_input_cond_filter.sv
// hwag_glitch_filter: two-flop synchroniser, run-length glitch filter and
// one-cycle transition detect on the filtered level (edge_pol selects direction).
module hwag_glitch_filter
    import hwag_input_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raw,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              edge_pol,
    output logic              level,
    output logic              trans
);

    logic              sync1;
    logic              sync2;
    logic              level_prev;
    logic [FILT_W-1:0] cnt;
    logic [FILT_W-1:0] eff_len;
    logic [FILT_W:0]   cnt_next;

    // A zero length would never match the incremented count, so it means one cycle.
    assign eff_len  = (filt_len == '0) ? FILT_W'(1) : filt_len;
    assign cnt_next = {1'b0, cnt} + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            level_prev <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt_next == {1'b0, eff_len}) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt_next[FILT_W-1:0];
            end
        end
    end

    assign trans = edge_pol ? (level & ~level_prev) : (~level & level_prev);

endmodule

// File: rtl/hwag_input_cond.sv
// Crank/cam input conditioner feeding hwag: filtering, edge qualification, blanking, tooth period.
// Optional rej_cnt output is enabled by defining HWAG_INPUT_REJCNT_EN.
module hwag_input_cond
    import hwag_input_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF,
    parameter int PER_W  = PER_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_raw,
    input  logic              cam_raw,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              cap_pol,
    input  blank_shf_t        blank_shf,
    output logic              cap,
    output logic              cap_edge,
    output logic              cam,
    output logic              cam_edge,
    output logic [PER_W-1:0]  period,
    output logic              period_valid,
    output logic              stall
`ifdef HWAG_INPUT_REJCNT_EN
    ,
    output logic [7:0]        rej_cnt
`endif
);

    localparam logic [PER_W-1:0] SAT_VAL = '1;

    logic             cap_trans;
    logic             cam_trans;
    logic [PER_W-1:0] pcnt;
    logic [PER_W-1:0] blank_len;
    logic             have_prev;
    logic             sat;
    logic             in_blank;
    logic             accept;
    logic             reject;

    hwag_glitch_filter #(.FILT_W(FILT_W)) u_crank (
        .clk      (clk),
        .rst      (rst),
        .raw      (cap_raw),
        .filt_len (filt_len),
        .edge_pol (cap_pol),
        .level    (cap),
        .trans    (cap_trans)
    );

    hwag_glitch_filter #(.FILT_W(FILT_W)) u_cam (
        .clk      (clk),
        .rst      (rst),
        .raw      (cam_raw),
        .filt_len (filt_len),
        .edge_pol (1'b1),
        .level    (cam),
        .trans    (cam_trans)
    );

    // Blanking only applies once a real period has been measured.
    assign blank_len = period >> ({1'b0, blank_shf} + 3'd1);
    assign sat       = (pcnt == SAT_VAL);
    assign in_blank  = period_valid && (pcnt < blank_len);
    assign accept    = cap_trans && !in_blank;
    assign reject    = cap_trans && in_blank;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_edge     <= 1'b0;
            cam_edge     <= 1'b0;
            pcnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
            have_prev    <= 1'b0;
        end else begin
            cap_edge <= accept;
            cam_edge <= cam_trans;
            // An edge on the saturation cycle restarts measurement as a first edge.
            if (accept) begin
                pcnt      <= '0;
                stall     <= 1'b0;
                have_prev <= 1'b1;
                if (have_prev && !sat) begin
                    period       <= pcnt + 1'b1;
                    period_valid <= 1'b1;
                end else begin
                    period_valid <= 1'b0;
                end
            end else if (sat) begin
                stall        <= 1'b1;
                period_valid <= 1'b0;
                have_prev    <= 1'b0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

`ifdef HWAG_INPUT_REJCNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rej_cnt <= '0;
        end else if (sat && !accept) begin
            rej_cnt <= '0;
        end else if (reject && (rej_cnt != 8'hFF)) begin
            rej_cnt <= rej_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/hwag_input_cond.md
Name: hwag_input_cond

Overview:
- Input conditioner directly upstream of hwag.
- Takes raw crank VR comparator and cam sensor pins.
- Synchronises, glitch-filters and edge-qualifies both inputs; rejects crank edges inside a period-proportional blanking window.
- Feeds hwag with clean cap/cam levels, a one-cycle accepted-tooth pulse and the last measured tooth period.

Parameters:
FILT_W, 8, width of filter length and filter counters
PER_W, 24, width of tooth period counter and period output

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
cap_raw  input  1  raw crank VR comparator output, asynchronous
cam_raw  input  1  raw cam sensor output, asynchronous
filt_len  input  FILT_W  consecutive stable cycles required to accept a level change
cap_pol  input  1  accepted crank edge: 1 = rising, 0 = falling
blank_shf  input  2  blanking window = last period >> (blank_shf+1)
cap  output  1  filtered crank level to hwag
cap_edge  output  1  one-cycle pulse per accepted crank edge
cam  output  1  filtered cam level to hwag
cam_edge  output  1  one-cycle pulse on filtered cam rising edge
period  output  PER_W  clocks between the last two accepted crank edges
period_valid  output  1  period holds a real measurement
stall  output  1  period counter saturated; engine considered stopped

Behaviour:
- Reset (rst==0 at posedge clk): sync flops 0, filter states 0, counters 0; cap=0, cam=0, cap_edge=0, cam_edge=0, period=0, period_valid=0, stall=0. Reset mid-operation discards any in-progress filter count and measurement.
- Synchroniser: 2 flops per input. Filter input is the second flop.
- Glitch filter, per input:
  - state bit and FILT_W counter.
  - sync != state: counter increments; state toggles and counter clears on the cycle counter+1 reaches eff_len.
  - sync == state: counter clears.
  - eff_len = filt_len, with 0 treated as 1.
  - Latency from raw change to filtered change: 2 + eff_len clocks.
- Edge detect on filtered state. Crank candidate = transition matching cap_pol. cam_edge = filtered cam 0->1, no blanking.
- Period counter pcnt (PER_W):
  - increments every clock; saturates at all-ones.
  - On saturation: stall=1, period_valid=0.
- Blanking:
  - blank_len = period >> (blank_shf+1), computed from the registered period.
  - A candidate is rejected if period_valid==1 and pcnt < blank_len.
  - Blanking is disabled while period_valid==0.
- Accepted candidate, same cycle as candidate detection (registered outputs next clock):
  - cap_edge=1 for one cycle.
  - If a previous edge has been accepted since reset/stall: period<=pcnt+1 and period_valid<=1.
  - Otherwise (first edge): period unchanged, period_valid stays 0.
  - pcnt<=0, stall<=0.
- Rejected candidate: no pulse, pcnt continues counting, period unchanged.
- Accepted edge on the saturation cycle: acceptance wins; it becomes the first edge of a new measurement and period_valid stays 0.
- Latency: raw crank edge to cap_edge = 2 + eff_len + 1 clocks.

Optional Feature:
HWAG_INPUT_REJCNT_EN
- Defined:
  - Adds output rej_cnt [7:0], a saturating count of rejected crank candidates.
  - Cleared on reset, and cleared on the cycle stall asserts.
  - A saturated count holds at 255.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package hwag_input_pkg:
  - FILT_W/PER_W default constants.
  - typedef for period word.
  - typedef for blank_shf.
  - localparam PCNT_MAX (all-ones).
- Sub-module hwag_glitch_filter (sync + counter + state + edge outputs), instantiated twice: crank and cam.

Test Plan:
- filt_len=4, cap_raw high 3 clocks then low -> cap never changes, cap_edge never pulses.
- filt_len=4, cap_pol=1, cap_raw 0->1 held -> cap rises 6 clocks later, cap_edge pulses at clock 7, for exactly 1 cycle.
- Accepted rising edges 200 clocks apart, blank_shf=1 -> period=200, period_valid=1. Extra rising edge 40 clocks after the last accepted edge (< 50) -> rejected; next edge at 200 -> accepted.
- PER_W=10, no edges for 1023+ clocks -> stall=1, period_valid=0. Next edge -> stall=0, no period update. Following edge -> period valid.
- cam_raw 0->1 with filt_len=0 -> cam rises 3 clocks later, cam_edge 1 cycle. Assert rst=0 mid-filter count -> all outputs 0 next clock.
- HWAG_INPUT_REJCNT_EN defined, 3 edges inside the blanking window -> rej_cnt=3. Force stall -> rej_cnt=0.
